// File: rtl/decode_writeback_if.sv
// Decode/writeback port bundle: fetch/execute side is the master,
// the register-file stage is the slave.
interface decode_writeback_if #(parameter int W = 64);
    logic [3:0]   icode;
    logic [3:0]   rA;
    logic [3:0]   rB;
    logic         cnd;
    logic [W-1:0] valE;
    logic [W-1:0] valM;
    logic         wb_en;
    logic [3:0]   srcA;
    logic [3:0]   srcB;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [3:0]   dbg_sel;
    logic [W-1:0] dbg_val;

    modport master (
        output icode, rA, rB, cnd, valE, valM, wb_en, dbg_sel,
        input  srcA, srcB, dstE, dstM, valA, valB, dbg_val
    );

    modport slave (
        input  icode, rA, rB, cnd, valE, valM, wb_en, dbg_sel,
        output srcA, srcB, dstE, dstM, valA, valB, dbg_val
    );
endinterface

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/writeback: fifteen W-bit program registers, combinational
// operand reads, one E write and one M write per clock edge.
module decode_writeback #(
    parameter int         W    = 64,
    parameter logic [3:0] RSP  = 4'h4,
    parameter logic [3:0] NONE = 4'hF
) (
    input logic clk,
    input logic rst_n,
    decode_writeback_if.slave dw
);
    localparam int NREG = 15;

    logic [W-1:0] regs [NREG];

    // Register-index decode from icode/rA/rB; cmovXX writes only when cnd holds
    always_comb begin
        dw.srcA = NONE;
        dw.srcB = NONE;
        dw.dstE = NONE;
        dw.dstM = NONE;
        case (dw.icode)
            4'h2: begin
                dw.srcA = dw.rA;
                dw.dstE = dw.cnd ? dw.rB : NONE;
            end
            4'h3: dw.dstE = dw.rB;
            4'h4: begin
                dw.srcA = dw.rA;
                dw.srcB = dw.rB;
            end
            4'h5: begin
                dw.srcB = dw.rB;
                dw.dstM = dw.rA;
            end
            4'h6: begin
                dw.srcA = dw.rA;
                dw.srcB = dw.rB;
                dw.dstE = dw.rB;
            end
            4'h8: begin
                dw.srcB = RSP;
                dw.dstE = RSP;
            end
            4'h9: begin
                dw.srcA = RSP;
                dw.srcB = RSP;
                dw.dstE = RSP;
            end
            4'hA: begin
                dw.srcA = dw.rA;
                dw.srcB = RSP;
                dw.dstE = RSP;
            end
            4'hB: begin
                dw.srcA = RSP;
                dw.srcB = RSP;
                dw.dstE = RSP;
                dw.dstM = dw.rA;
            end
            default: ;
        endcase
    end

    // Register writes; the M port takes priority so popq %rsp lands valM.
    // Index 15 never matches any storage slot, so such writes vanish.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                regs[i] <= '0;
            else if (dw.wb_en) begin
                if (dw.dstM == 4'(i))
                    regs[i] <= dw.valM;
                else if (dw.dstE == 4'(i))
                    regs[i] <= dw.valE;
            end
        end
    end

    // Combinational read ports; index 15 reads as zero, no same-cycle bypass
    always_comb begin
        dw.valA    = '0;
        dw.valB    = '0;
        dw.dbg_val = '0;
        for (int i = 0; i < NREG; i++) begin
            if (dw.srcA == 4'(i))    dw.valA    = regs[i];
            if (dw.srcB == 4'(i))    dw.valB    = regs[i];
            if (dw.dbg_sel == 4'(i)) dw.dbg_val = regs[i];
        end
    end
endmodule
